// File: rtl/jogador_automatico.sv
// Automatic player for circuito_exp7: drives iniciar/botoes, replays the stored sequence
// round by round and latches the final result. Optional macro: JOGADOR_PARADA_ANTECIPADA_EN.
module jogador_automatico #(
  parameter logic [63:0] SEQ       = 64'h4188_4422_1124_8421,
  parameter int          T_INICIAR = 5,
  parameter int          T_ESPERA  = 2000,
  parameter int          T_PRESS   = 10,
  parameter int          T_SOLTA   = 10,
  parameter int          T_FIM     = 4000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic       perder_en,
  input  logic [3:0] rodada_perder,
  input  logic [3:0] jogada_perder,
  input  logic [3:0] botoes_perder,
  input  logic       pronto,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       iniciar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       fim,
  output logic       res_ganhou,
  output logic       res_perdeu,
  output logic       res_timeout,
  output logic [3:0] db_rodada,
  output logic [3:0] db_jogada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    INICIA    = 4'd1,
    ESPERA    = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4,
    PROXIMA   = 4'd5,
    AGUARDA   = 4'd6,
    FIM       = 4'd7
  } estado_t;

  localparam logic [15:0] CARGA_INICIAR = 16'(T_INICIAR - 1);
  localparam logic [15:0] CARGA_ESPERA  = 16'(T_ESPERA - 1);
  localparam logic [15:0] CARGA_PRESS   = 16'(T_PRESS - 1);
  localparam logic [15:0] CARGA_SOLTA   = 16'(T_SOLTA - 1);
  localparam logic [15:0] CARGA_FIM     = 16'(T_FIM - 1);

  estado_t     estado, estado_n;
  logic [3:0]  rodada, rodada_n;
  logic [3:0]  jogada, jogada_n;
  logic [15:0] timer, timer_n;
  logic        injetado, injetado_n;
  logic [3:0]  botoes_n;
  logic        res_ganhou_n, res_perdeu_n, res_timeout_n;

  function automatic logic [3:0] seq_at(input logic [3:0] k);
    seq_at = SEQ[{k, 2'b00} +: 4];
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    estado_n      = estado;
    rodada_n      = rodada;
    jogada_n      = jogada;
    injetado_n    = injetado;
    botoes_n      = botoes;
    res_ganhou_n  = res_ganhou;
    res_perdeu_n  = res_perdeu;
    res_timeout_n = res_timeout;
    timer_n       = (timer == 16'd0) ? 16'd0 : timer - 16'd1;

    unique case (estado)
      OCIOSO, FIM: begin
        if (partida) begin
          estado_n      = INICIA;
          rodada_n      = 4'd0;
          jogada_n      = 4'd0;
          injetado_n    = 1'b0;
          res_ganhou_n  = 1'b0;
          res_perdeu_n  = 1'b0;
          res_timeout_n = 1'b0;
        end
      end
      INICIA:    if (timer == 16'd0) estado_n = ESPERA;
      ESPERA:    if (timer == 16'd0) estado_n = PRESSIONA;
      PRESSIONA: if (timer == 16'd0) estado_n = SOLTA;
      SOLTA:     if (timer == 16'd0) estado_n = PROXIMA;
      PROXIMA: begin
        // The last round has no insert: it ends after replaying play 15.
        if (injetado || (rodada == 4'd15 && jogada == 4'd15)) begin
          estado_n = AGUARDA;
        end else if ({1'b0, jogada} < ({1'b0, rodada} + 5'd1)) begin
          jogada_n = jogada + 4'd1;
          estado_n = PRESSIONA;
        end else begin
          rodada_n = rodada + 4'd1;
          jogada_n = 4'd0;
          estado_n = PRESSIONA;
        end
      end
      AGUARDA: begin
        if (pronto) begin
          res_ganhou_n = ganhou;
          res_perdeu_n = perdeu;
          estado_n     = FIM;
        end else if (timer == 16'd0) begin
          res_timeout_n = 1'b1;
          estado_n      = FIM;
        end
      end
      default: estado_n = OCIOSO;
    endcase

`ifdef JOGADOR_PARADA_ANTECIPADA_EN
    if (pronto && (estado == PRESSIONA || estado == SOLTA || estado == PROXIMA)) begin
      estado_n     = FIM;
      rodada_n     = rodada;
      jogada_n     = jogada;
      res_ganhou_n = ganhou;
      res_perdeu_n = perdeu;
    end
`endif

    if (estado_n != estado) begin
      unique case (estado_n)
        INICIA:    timer_n = CARGA_INICIAR;
        ESPERA:    timer_n = CARGA_ESPERA;
        PRESSIONA: timer_n = CARGA_PRESS;
        SOLTA:     timer_n = CARGA_SOLTA;
        AGUARDA:   timer_n = CARGA_FIM;
        default:   timer_n = 16'd0;
      endcase
    end

    // The press value is fixed on PRESSIONA entry and held for the whole press.
    if (estado_n != PRESSIONA) begin
      botoes_n = 4'd0;
    end else if (estado != PRESSIONA) begin
      injetado_n = perder_en && (rodada_n == rodada_perder) && (jogada_n == jogada_perder);
      botoes_n   = injetado_n ? botoes_perder : seq_at(jogada_n);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= OCIOSO;
      rodada      <= 4'd0;
      jogada      <= 4'd0;
      timer       <= 16'd0;
      injetado    <= 1'b0;
      iniciar     <= 1'b0;
      botoes      <= 4'd0;
      ocupado     <= 1'b0;
      fim         <= 1'b0;
      res_ganhou  <= 1'b0;
      res_perdeu  <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      estado      <= estado_n;
      rodada      <= rodada_n;
      jogada      <= jogada_n;
      timer       <= timer_n;
      injetado    <= injetado_n;
      iniciar     <= (estado_n == INICIA);
      botoes      <= botoes_n;
      ocupado     <= (estado_n != OCIOSO) && (estado_n != FIM);
      fim         <= (estado_n == FIM);
      res_ganhou  <= res_ganhou_n;
      res_perdeu  <= res_perdeu_n;
      res_timeout <= res_timeout_n;
    end
  end

  assign db_rodada = rodada;
  assign db_jogada = jogada;
  assign db_estado = estado;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: expected press lists are generated from the round/play rules,
// a small game model answers with pronto/ganhou/perdeu, and timing is measured at negedges.
module tb_jogador_automatico;

  localparam logic [63:0] SEQ_REF = 64'h4188_4422_1124_8421;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       partida = 1'b0;
  logic       perder_en = 1'b0;
  logic [3:0] rodada_perder = 4'd0;
  logic [3:0] jogada_perder = 4'd0;
  logic [3:0] botoes_perder = 4'd0;
  logic       pronto = 1'b0;
  logic       ganhou = 1'b0;
  logic       perdeu = 1'b0;
  logic       iniciar;
  logic [3:0] botoes;
  logic       ocupado, fim, res_ganhou, res_perdeu, res_timeout;
  logic [3:0] db_rodada, db_jogada, db_estado;

  int checks = 0;
  int errors = 0;

  jogador_automatico dut (
    .clock(clock), .reset(reset), .partida(partida), .perder_en(perder_en),
    .rodada_perder(rodada_perder), .jogada_perder(jogada_perder), .botoes_perder(botoes_perder),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .iniciar(iniciar), .botoes(botoes),
    .ocupado(ocupado), .fim(fim), .res_ganhou(res_ganhou), .res_perdeu(res_perdeu),
    .res_timeout(res_timeout), .db_rodada(db_rodada), .db_jogada(db_jogada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] seq_of(input int j);
    logic [63:0] s;
    s = SEQ_REF;
    return s[4*j +: 4];
  endfunction

  // Plays one full game and checks every press plus the final result.
  task automatic run_game(input string nome, input bit inj_en, input logic [3:0] rp,
                          input logic [3:0] jp, input logic [3:0] bp, input bit responde);
    logic [3:0] exp_q[$];
    bit         hit, estavel, extra;
    int         n, atraso, ultimo;
    logic [3:0] v;

    hit = 1'b0;
    for (int r = 0; r < 16 && !hit; r++) begin
      ultimo = (r == 15) ? 15 : r + 1;
      for (int j = 0; j <= ultimo && !hit; j++) begin
        if (inj_en && r == int'(rp) && j == int'(jp)) begin
          exp_q.push_back(bp);
          hit = 1'b1;
        end else begin
          exp_q.push_back(seq_of(j));
        end
      end
    end

    perder_en = inj_en; rodada_perder = rp; jogada_perder = jp; botoes_perder = bp;
    @(negedge clock);
    partida = 1'b1;          // held until the first press: must be ignored while busy
    @(negedge clock);
    n = 0;
    while (iniciar === 1'b1 && n < 50) begin n++; @(negedge clock); end
    check({nome, "_iniciar_len"}, n, 5);
    n = 0;
    while (botoes === 4'd0 && n < 3000) begin n++; @(negedge clock); end
    check({nome, "_espera"}, n, 2000);
    partida = 1'b0;

    foreach (exp_q[i]) begin
      v = botoes; n = 0; estavel = 1'b1;
      while (botoes !== 4'd0 && n < 50) begin
        if (botoes !== v) estavel = 1'b0;
        n++; @(negedge clock);
      end
      check($sformatf("%s_valor_%0d", nome, i), v, exp_q[i]);
      check($sformatf("%s_dur_%0d", nome, i), n, 10);
      check($sformatf("%s_estavel_%0d", nome, i), estavel, 1);
      if (i < exp_q.size() - 1) begin
        n = 0;
        while (botoes === 4'd0 && n < 100) begin n++; @(negedge clock); end
        check($sformatf("%s_gap_%0d", nome, i), (n >= 10 && n < 100), 1);
      end
    end

    atraso = $urandom_range(5, 60);
    n = 0; extra = 1'b0;
    while (fim !== 1'b1 && n < 4300) begin
      if (botoes !== 4'd0) extra = 1'b1;
      n++;
      if (responde && n == atraso) begin pronto = 1'b1; ganhou = !hit; perdeu = hit; end
      @(negedge clock);
    end
    check({nome, "_sem_press_extra"}, extra, 0);
    check({nome, "_fim"}, fim, 1);
    if (!responde) check({nome, "_latencia_timeout"}, n, 10 + 1 + 4000);
    check({nome, "_res_ganhou"}, res_ganhou, responde && !hit);
    check({nome, "_res_perdeu"}, res_perdeu, responde && hit);
    check({nome, "_res_timeout"}, res_timeout, !responde);
    check({nome, "_ocupado"}, ocupado, 0);
    pronto = 1'b0; ganhou = 1'b0; perdeu = 1'b0;
    repeat (3) @(negedge clock);
    check({nome, "_fim_mantido"}, fim, 1);
    check({nome, "_res_mantido"}, {res_ganhou, res_perdeu, res_timeout},
          {responde && !hit, responde && hit, !responde});
  endtask

  task automatic pulse_partida();
    @(negedge clock);
    partida = 1'b1;
    @(negedge clock);
    partida = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("reset_saidas", {iniciar, botoes, ocupado, fim, res_ganhou, res_perdeu, res_timeout},
          '0);
    check("reset_db", {db_rodada, db_jogada, db_estado}, '0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("ocioso_estado", db_estado, 0);

    run_game("vitoria", 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    run_game("perda_r2j1", 1'b1, 4'd2, 4'd1, 4'b0001, 1'b1);
    run_game("timeout", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    run_game("fora_alcance", 1'b1, 4'd1, 4'd5, 4'b1000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] rp, jp, bp;
      rp = 4'($urandom_range(0, 5));
      jp = 4'($urandom_range(0, int'(rp) + 1));
      bp = 4'(1 << $urandom_range(0, 3));
      run_game($sformatf("perda_rand%0d", k), 1'b1, rp, jp, bp, 1'b1);
    end

    // Async reset while iniciar is high.
    perder_en = 1'b0;
    pulse_partida();
    n = 0;
    while (iniciar !== 1'b1 && n < 20) begin n++; @(negedge clock); end
    #2 reset = 1'b0;
    #1 check("rst_iniciar_cai", iniciar, 0);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check("rst_iniciar_estado", db_estado, 0);

    // Async reset mid-press at round 3.
    pulse_partida();
    n = 0;
    while (!(db_rodada === 4'd3 && botoes !== 4'd0) && n < 5000) begin n++; @(negedge clock); end
    check("rst_alcancou_r3", (botoes !== 4'd0), 1);
    #2 reset = 1'b0;
    #1 check("rst_botoes_cai", {iniciar, botoes}, 0);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check("rst_estado_ocioso", db_estado, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_rodada", db_rodada, 0);

`ifdef JOGADOR_PARADA_ANTECIPADA_EN
    pulse_partida();
    n = 0;
    while (!(db_rodada === 4'd4 && botoes !== 4'd0) && n < 6000) begin n++; @(negedge clock); end
    pronto = 1'b1; perdeu = 1'b1;
    @(negedge clock);
    check("antecipada_fim", fim, 1);
    check("antecipada_botoes", botoes, 0);
    check("antecipada_res", {res_ganhou, res_perdeu, res_timeout}, 3'b010);
    pronto = 1'b0; perdeu = 1'b0;
    @(negedge clock);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
